// File: rtl/cntr_modulus_prog.sv
// Programmable-modulus up/down counter.
// q always stays within 0..M-1, where M is an internal modulus register
// loaded at reset (DEFAULT_MOD) or by an accepted mod_load (mod_val >= 2).
// The at_max/at_zero flags are registered lookahead flags. They are computed
// from next-state candidates, so the wrap decision comes straight from a
// flip-flop instead of a q-versus-M comparator.
module cntr_modulus_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_MOD = 50223
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             sclear,
    input  logic             sload,
    input  logic [WIDTH-1:0] sdata,
    input  logic             up,
    input  logic             mod_load,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             at_max_r;
    logic             at_zero_r;
    logic             wrap_r;

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] m_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             wrap_s;
    logic             mod_accept_s;
    logic             sdata_fits_s;

    // Qualify a modulus request: a modulus below 2 is not usable, so it is ignored.
    always_comb begin
        mod_accept_s = 1'b0;
        sdata_fits_s = 1'b0;
        if (mod_load && (mod_val >= WIDTH'(2))) begin
            mod_accept_s = 1'b1;
        end else begin
            mod_accept_s = 1'b0;
        end
        if (sdata < m_r) begin
            sdata_fits_s = 1'b1;
        end else begin
            sdata_fits_s = 1'b0;
        end
    end

    // Next-state selection in priority order: clear/modulus change > load > count > hold.
    always_comb begin
        q_s       = q_r;
        m_s       = m_r;
        at_max_s  = at_max_r;
        at_zero_s = at_zero_r;
        wrap_s    = 1'b0;
        if (sclear || mod_accept_s) begin
            // The new modulus is at least 2, so q = 0 can never equal M-1.
            if (mod_accept_s) begin
                m_s = mod_val;
            end else begin
                m_s = m_r;
            end
            q_s       = '0;
            at_zero_s = 1'b1;
            at_max_s  = 1'b0;
        end else if (ena && sload) begin
            // An out-of-range load value collapses to 0.
            if (sdata_fits_s) begin
                q_s       = sdata;
                at_zero_s = (sdata == '0);
                at_max_s  = (sdata == (m_r - WIDTH'(1)));
            end else begin
                q_s       = '0;
                at_zero_s = 1'b1;
                at_max_s  = 1'b0;
            end
        end else if (ena) begin
            if (up) begin
                // Going up: wrap from M-1 to 0; the next value is M-1 only if q is M-2 now.
                wrap_s    = at_max_r;
                at_zero_s = at_max_r;
                at_max_s  = (q_r == (m_r - WIDTH'(2)));
                if (at_max_r) begin
                    q_s = '0;
                end else begin
                    q_s = q_r + WIDTH'(1);
                end
            end else begin
                // Going down: wrap from 0 to M-1; the next value is 0 only if q is 1 now.
                wrap_s    = at_zero_r;
                at_max_s  = at_zero_r;
                at_zero_s = (q_r == WIDTH'(1));
                if (at_zero_r) begin
                    q_s = m_r - WIDTH'(1);
                end else begin
                    q_s = q_r - WIDTH'(1);
                end
            end
        end else begin
            wrap_s = 1'b0;
        end
    end

    // State registers with synchronous reset to the default modulus.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= '0;
            m_r       <= WIDTH'(DEFAULT_MOD);
            at_max_r  <= 1'b0;
            at_zero_r <= 1'b1;
            wrap_r    <= 1'b0;
        end else begin
            q_r       <= q_s;
            m_r       <= m_s;
            at_max_r  <= at_max_s;
            at_zero_r <= at_zero_s;
            wrap_r    <= wrap_s;
        end
    end

    // Outputs: registered values, with tc a single mux behind the flag registers.
    always_comb begin
        q    = q_r;
        wrap = wrap_r;
        if (up) begin
            tc = at_max_r;
        end else begin
            tc = at_zero_r;
        end
    end

endmodule

// File: doc/cntr_modulus_prog.md
CNTR_MODULUS_PROG -- requirements
Module: cntr_modulus_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter and modulus width in bits.
REQ-002 SHALL have parameter DEFAULT_MOD, default 50223: modulus after reset, legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port ena  input  1: count/load enable.
REQ-006 SHALL have port sclear  input  1: synchronous clear to 0.
REQ-007 SHALL have port sload  input  1: synchronous load from sdata.
REQ-008 SHALL have port sdata  input  WIDTH: load value.
REQ-009 SHALL have port up  input  1: direction, 1 = increment, 0 = decrement.
REQ-010 SHALL have port mod_load  input  1: request to replace the modulus register M with mod_val.
REQ-011 SHALL have port mod_val  input  WIDTH: new modulus.
REQ-012 SHALL have port q  output  WIDTH: count value, always in 0..M-1.
REQ-013 SHALL have port tc  output  1: terminal count, q==M-1 when up=1, q==0 when up=0.
REQ-014 SHALL have port wrap  output  1: registered one-cycle pulse after a counting wrap.

Function
REQ-015 M SHALL be an internal WIDTH-bit register loaded only by reset or an accepted mod_load.
REQ-016 A mod_load SHALL be accepted only when mod_val>=2; otherwise M, q and flags are unchanged by it.
REQ-017 Per-edge priority, independent of ena for the first two: rst > sclear or accepted mod_load > (ena & sload) > (ena & count) > hold.
REQ-018 sclear SHALL set q=0; accepted mod_load SHALL set M=mod_val and q=0 in the same edge, sclear concurrently still yielding q=0.
REQ-019 ena & sload SHALL set q=sdata if sdata<M, else q=0.
REQ-020 Counting up SHALL step q to q+1, and from M-1 to 0.
REQ-021 Counting down SHALL step q to q-1, and from 0 to M-1.
REQ-022 ena=0 SHALL hold q; sclear and mod_load still act when ena=0.
REQ-023 Two registered lookahead flags SHALL exist: at_max (q==M-1) and at_zero (q==0), each valid in the same cycle as q.
REQ-024 Flags SHALL be computed from next-state candidates (q==M-2, q==1, sdata/M compares, mod_load), so that no q-versus-M compare sits on the count-wrap path.
REQ-025 tc SHALL be up ? at_max : at_zero (one gate after registers).
REQ-026 wrap SHALL be 1 for exactly one cycle after an edge where a count step wrapped (M-1->0 up, 0->M-1 down); it SHALL be 0 after sclear/sload/mod_load edges.
REQ-027 A direction change SHALL take effect on the next counting edge with no lost or extra step.
REQ-028 Arithmetic SHALL be modulo M only; no intermediate wider than WIDTH+1 bits.

Reset
REQ-029 rst=1 SHALL set q=0, M=DEFAULT_MOD, at_zero=1, at_max=0, wrap=0 at the edge, overriding all other inputs.
REQ-030 After reset, tc SHALL equal !up.
REQ-031 Reset asserted mid-count or after a mod_load SHALL restore M=DEFAULT_MOD.

Verification (bench WIDTH=4, DEFAULT_MOD=10)
REQ-032 Reset, up=1, ena=1 for 12 edges -> q=1..9,0,1,2; tc=1 while q=9; wrap=1 only in the cycle q=0 after 9.
REQ-033 Reset, up=0, ena=1 -> q=9,8,7; tc=1 at q=0 before the first edge; wrap=1 in the cycle q=9.
REQ-034 sload sdata=12 -> q=0; sload sdata=7 -> q=7; sload=7 with sclear=1 -> q=0; wrap stays 0 throughout.
REQ-035 At q=7, mod_load mod_val=5 with ena=0 -> q=0, M=5; then counting up gives 1,2,3,4,0; mod_load mod_val=1 -> ignored, counting continues.
REQ-036 At q=9 with up=1, drop up to 0 -> q=8, wrap=0, tc falls; ena=0 for 3 edges -> q holds 8.
REQ-037 After mod_load mod_val=5 at q=3, rst=1 -> q=0, then 10-step wrap period restored.
